tw_arbiter: RTL
===============

TW_ARBITER -- requirements
Module: tw_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 9, threewire address width.
REQ-002 Parameter DATA_BITS, default 16, threewire data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, watchdog limit in in_clk cycles (8-bit counter, range 1..255).
REQ-004 in_clk  input  1  single clock; all logic on rising edge.
REQ-005 in_rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_req0 / in_req1  input  1 each  requester 0/1 transaction request, level.
REQ-007 in_wr0 / in_wr1  input  1 each  1 = write, 0 = read.
REQ-008 in_addr0 / in_addr1  input  ADDR_BITS each  target address.
REQ-009 in_wdata0 / in_wdata1  input  DATA_BITS each  write data.
REQ-010 out_done0 / out_done1  output  1 each  one-cycle completion pulse to owning requester.
REQ-011 out_rd_data  output  DATA_BITS  read data of last completed read, shared.
REQ-012 out_err  output  1  timeout flag, pulses with out_doneN.
REQ-013 out_busy  output  1  high whenever state is not IDLE.
REQ-014 out_tw_mode_wr, out_tw_addr, out_tw_wr_data  output  1/ADDR_BITS/DATA_BITS  to threewire controller.
REQ-015 out_tw_start  output  1  start strobe to threewire controller.
REQ-016 in_tw_rd_data  input  DATA_BITS  threewire read data; in_tw_in_progress  input  1  threewire busy.

Function
REQ-017 States SHALL be IDLE, START, WAIT_DONE, COMPLETE; all outputs registered.
REQ-018 IDLE: any in_reqN high -> latch winner's wr/addr/wdata into out_tw_* and owner register, go START next edge.
REQ-019 Arbitration SHALL be round-robin: single request wins; both high -> requester not served last wins; last-served resets to 1 (requester 0 wins first tie).
REQ-020 START: out_tw_start = 1; when in_tw_in_progress = 1 -> WAIT_DONE, out_tw_start = 0 on that edge.
REQ-021 WAIT_DONE: when in_tw_in_progress = 0 -> COMPLETE.
REQ-022 COMPLETE (one cycle): out_doneN = 1 for owner only; if latched op was read, out_rd_data <= in_tw_rd_data on entry; writes leave out_rd_data unchanged; next state IDLE.
REQ-023 Requests SHALL be sampled only in IDLE; out_tw_* SHALL stay stable from START through COMPLETE regardless of requester inputs.
REQ-024 Requester SHALL deassert in_reqN the cycle after out_doneN; a request still high in IDLE is a new transaction.
REQ-025 Request from the non-owner during a transaction SHALL be held pending (not lost) while its in_reqN stays high, and wins next IDLE by round-robin.
REQ-026 Latency: in_req edge to out_tw_start high = 1 cycle; in_tw_in_progress fall to out_doneN = 1 cycle; IDLE re-arbitrates the cycle after COMPLETE.

Reset
REQ-027 in_rst_n low SHALL immediately force IDLE, out_tw_start = 0, out_done0/1 = 0, out_err = 0, out_busy = 0, out_rd_data = 0, out_tw_* = 0, owner = 0, last-served = 1, watchdog = 0.
REQ-028 Reset mid-transaction SHALL abandon it with no out_doneN pulse; threewire controller reset is external.

Configuration
REQ-029 Macro TW_ARBITER_TIMEOUT_EN defined: 8-bit watchdog clears on leaving IDLE, increments each cycle in START/WAIT_DONE; reaching TIMEOUT_CYCLES -> COMPLETE with out_err = 1 and owner's done pulse, out_rd_data unchanged.
REQ-030 Macro undefined: no watchdog logic, out_err tied 0, START/WAIT_DONE wait indefinitely.

Verification
REQ-031 Req0 write addr 0x05A data 0xBEEF alone -> out_tw_start next cycle, out_tw_* = 1/0x05A/0xBEEF, single out_done0, out_rd_data stays 0.
REQ-032 Req1 read addr 0x1FF, model returns 0x1234 -> out_done1 pulse, out_rd_data = 0x1234, out_done0 never high.
REQ-033 Req0 and req1 rise same cycle after reset, held -> order 0,1,0,1 across four transactions.
REQ-034 Req1 rises during req0 WAIT_DONE -> req1 served immediately after req0 COMPLETE; addr0 not altered mid-transaction when in_addr0 changes.
REQ-035 Macro defined, TIMEOUT_CYCLES = 20, model never raises in_tw_in_progress -> out_done0 and out_err pulse together 20 cycles after START, then IDLE.
REQ-036 in_rst_n low during WAIT_DONE -> all outputs zero same cycle, no done pulse; first tie after release goes to requester 0.

Source files
------------

// File: rtl/tw_arbiter_if.sv
// Requester/threewire-side bundle for tw_arbiter: two requester ports, the
// shared completion outputs and the threewire controller handshake.
interface tw_arbiter_if #(
    parameter int ADDR_BITS = 9,
    parameter int DATA_BITS = 16
);
    logic                 in_req0;
    logic                 in_req1;
    logic                 in_wr0;
    logic                 in_wr1;
    logic [ADDR_BITS-1:0] in_addr0;
    logic [ADDR_BITS-1:0] in_addr1;
    logic [DATA_BITS-1:0] in_wdata0;
    logic [DATA_BITS-1:0] in_wdata1;
    logic                 out_done0;
    logic                 out_done1;
    logic [DATA_BITS-1:0] out_rd_data;
    logic                 out_err;
    logic                 out_busy;
    logic                 out_tw_mode_wr;
    logic [ADDR_BITS-1:0] out_tw_addr;
    logic [DATA_BITS-1:0] out_tw_wr_data;
    logic                 out_tw_start;
    logic [DATA_BITS-1:0] in_tw_rd_data;
    logic                 in_tw_in_progress;

    // Arbiter side.
    modport slave (
        input  in_req0, in_req1, in_wr0, in_wr1, in_addr0, in_addr1,
               in_wdata0, in_wdata1, in_tw_rd_data, in_tw_in_progress,
        output out_done0, out_done1, out_rd_data, out_err, out_busy,
               out_tw_mode_wr, out_tw_addr, out_tw_wr_data, out_tw_start
    );

    // Requester / threewire-controller side.
    modport master (
        output in_req0, in_req1, in_wr0, in_wr1, in_addr0, in_addr1,
               in_wdata0, in_wdata1, in_tw_rd_data, in_tw_in_progress,
        input  out_done0, out_done1, out_rd_data, out_err, out_busy,
               out_tw_mode_wr, out_tw_addr, out_tw_wr_data, out_tw_start
    );
endinterface

// File: rtl/tw_arbiter.sv
// Two-requester round-robin arbiter in front of a threewire controller.
// Optional watchdog enabled by defining TW_ARBITER_TIMEOUT_EN.
module tw_arbiter #(
    parameter int ADDR_BITS      = 9,
    parameter int DATA_BITS      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    tw_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_COMPLETE  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_owner;
    logic                 r_last;
    logic                 r_tw_start;
    logic                 r_done0;
    logic                 r_done1;
    logic                 r_busy;
    logic [DATA_BITS-1:0] r_rd_data;
    logic                 r_tw_mode_wr;
    logic [ADDR_BITS-1:0] r_tw_addr;
    logic [DATA_BITS-1:0] r_tw_wr_data;

    logic                 w_any_req;
    logic                 w_winner;
    logic                 w_win_wr;
    logic [ADDR_BITS-1:0] w_win_addr;
    logic [DATA_BITS-1:0] w_win_wdata;

`ifdef TW_ARBITER_TIMEOUT_EN
    localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_wdog;
    logic       r_err;
    logic       w_wdog_expired;

    // Watchdog expiry: compared at the edge that would count the limit cycle.
    always_comb begin
        w_wdog_expired = 1'b0;
        if (r_wdog >= WDOG_LIMIT) begin
            w_wdog_expired = 1'b1;
        end else begin
            w_wdog_expired = 1'b0;
        end
    end
`endif

    // Round-robin winner: on a tie the requester not served last wins.
    always_comb begin
        w_any_req   = bus.in_req0 | bus.in_req1;
        w_winner    = 1'b0;
        w_win_wr    = bus.in_wr0;
        w_win_addr  = bus.in_addr0;
        w_win_wdata = bus.in_wdata0;
        if (bus.in_req0 && bus.in_req1) begin
            w_winner = ~r_last;
        end else begin
            w_winner = bus.in_req1;
        end
        if (w_winner) begin
            w_win_wr    = bus.in_wr1;
            w_win_addr  = bus.in_addr1;
            w_win_wdata = bus.in_wdata1;
        end else begin
            w_win_wr    = bus.in_wr0;
            w_win_addr  = bus.in_addr0;
            w_win_wdata = bus.in_wdata0;
        end
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last       <= 1'b1;
            r_tw_start   <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_busy       <= 1'b0;
            r_rd_data    <= {DATA_BITS{1'b0}};
            r_tw_mode_wr <= 1'b0;
            r_tw_addr    <= {ADDR_BITS{1'b0}};
            r_tw_wr_data <= {DATA_BITS{1'b0}};
`ifdef TW_ARBITER_TIMEOUT_EN
            r_wdog       <= 8'd0;
            r_err        <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    if (w_any_req) begin
                        r_owner      <= w_winner;
                        r_tw_mode_wr <= w_win_wr;
                        r_tw_addr    <= w_win_addr;
                        r_tw_wr_data <= w_win_wdata;
                        r_tw_start   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_START;
`ifdef TW_ARBITER_TIMEOUT_EN
                        r_wdog       <= 8'd0;
`endif
                    end else begin
                        r_tw_start <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_START: begin
`ifdef TW_ARBITER_TIMEOUT_EN
                    r_wdog <= r_wdog + 8'd1;
                    if (w_wdog_expired) begin
                        r_tw_start <= 1'b0;
                        r_done0    <= ~r_owner;
                        r_done1    <= r_owner;
                        r_err      <= 1'b1;
                        r_last     <= r_owner;
                        r_state    <= ST_COMPLETE;
                    end else
`endif
                    if (bus.in_tw_in_progress) begin
                        r_tw_start <= 1'b0;
                        r_state    <= ST_WAIT_DONE;
                    end else begin
                        r_tw_start <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_WAIT_DONE: begin
`ifdef TW_ARBITER_TIMEOUT_EN
                    r_wdog <= r_wdog + 8'd1;
`endif
                    if (!bus.in_tw_in_progress) begin
                        r_done0 <= ~r_owner;
                        r_done1 <= r_owner;
                        r_last  <= r_owner;
                        r_state <= ST_COMPLETE;
                        if (!r_tw_mode_wr) begin
                            r_rd_data <= bus.in_tw_rd_data;
                        end else begin
                            r_rd_data <= r_rd_data;
                        end
                    end
`ifdef TW_ARBITER_TIMEOUT_EN
                    // A real completion on the expiry edge wins over the timeout.
                    else if (w_wdog_expired) begin
                        r_done0 <= ~r_owner;
                        r_done1 <= r_owner;
                        r_err   <= 1'b1;
                        r_last  <= r_owner;
                        r_state <= ST_COMPLETE;
                    end
`endif
                    else begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_COMPLETE: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
`ifdef TW_ARBITER_TIMEOUT_EN
                    r_err   <= 1'b0;
`endif
                end
                default: begin
                    r_tw_start <= 1'b0;
                    r_done0    <= 1'b0;
                    r_done1    <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
`ifdef TW_ARBITER_TIMEOUT_EN
                    r_err      <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign bus.out_done0      = r_done0;
    assign bus.out_done1      = r_done1;
    assign bus.out_rd_data    = r_rd_data;
    assign bus.out_busy       = r_busy;
    assign bus.out_tw_mode_wr = r_tw_mode_wr;
    assign bus.out_tw_addr    = r_tw_addr;
    assign bus.out_tw_wr_data = r_tw_wr_data;
    assign bus.out_tw_start   = r_tw_start;
`ifdef TW_ARBITER_TIMEOUT_EN
    assign bus.out_err        = r_err;
`else
    assign bus.out_err        = 1'b0;
`endif
endmodule
